// File: rtl/ext_mem_wb_bridge.sv
// Registered Wishbone-classic bridge with a timeout watchdog and fault statistics; `EXT_BRIDGE_POSTED_WR_EN enables posted writes.
// Latency: request sampled cycle 0, m_stb_o cycle 1, s_ack_o/s_err_o one cycle after m_ack_i/m_err_i/timeout.
// Backpressure: one access in flight; a new request is only accepted once the bridge is back in IDLE.
module ext_mem_wb_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TCNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     s_adr_i,
  input  logic [DATA_W-1:0]     s_dat_i,
  output logic [DATA_W-1:0]     s_dat_o,
  input  logic                  s_we_i,
  input  logic [DATA_W/8-1:0]   s_sel_i,
  input  logic                  s_cyc_i,
  input  logic                  s_stb_i,
  output logic                  s_ack_o,
  output logic                  s_err_o,
  output logic [ADDR_W-1:0]     m_adr_o,
  output logic [DATA_W-1:0]     m_dat_o,
  output logic                  m_we_o,
  output logic [DATA_W/8-1:0]   m_sel_o,
  output logic                  m_cyc_o,
  output logic                  m_stb_o,
  input  logic [DATA_W-1:0]     m_dat_i,
  input  logic                  m_ack_i,
  input  logic                  m_err_i,
  input  logic                  stat_clr_i,
  output logic                  busy_o,
  output logic                  timeout_flag_o,
  output logic [TCNT_W-1:0]     timeout_cnt_o,
  output logic                  posted_err_o
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [TMR_W-1:0]  timer_q;
  logic              abort_q;
  logic              posted_q;
  logic              accept;
  logic              dn_ack;
  logic              dn_err;
  logic              tmo;
  logic              done;
  logic              resp_ok;
  logic [TCNT_W-1:0] cnt_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    dn_ack  = 1'b0;
    dn_err  = 1'b0;
    tmo     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Error beats a simultaneous ack; the watchdog only fires when the slave is silent.
        if (m_err_i) begin
          dn_err = 1'b1;
        end else if (m_ack_i) begin
          dn_ack = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          tmo = 1'b1;
        end
        done = dn_err | dn_ack | tmo;
        if (done) begin
          state_d = posted_q ? IDLE : RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // An upstream that dropped cyc at any point of the access gets no response pulse.
  assign resp_ok  = done && !posted_q && !abort_q && s_cyc_i;
  assign cnt_base = stat_clr_i ? '0 : timeout_cnt_o;
  assign busy_o   = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      abort_q <= 1'b0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      s_dat_o <= '0;
      s_ack_o <= 1'b0;
      s_err_o <= 1'b0;
    end else begin
      s_ack_o <= 1'b0;
      s_err_o <= 1'b0;
      if (accept) begin
        m_adr_o <= s_adr_i;
        m_dat_o <= s_dat_i;
        m_we_o  <= s_we_i;
        m_sel_o <= s_sel_i;
        m_cyc_o <= 1'b1;
        m_stb_o <= 1'b1;
        timer_q <= '0;
        abort_q <= 1'b0;
`ifdef EXT_BRIDGE_POSTED_WR_EN
        if (s_we_i) begin
          s_ack_o <= 1'b1;
        end
`endif
      end
      if (state_q == ACCESS) begin
        timer_q <= timer_q + 1'b1;
        if (!s_cyc_i) begin
          abort_q <= 1'b1;
        end
        if (done) begin
          m_cyc_o <= 1'b0;
          m_stb_o <= 1'b0;
        end
        if (dn_ack && !m_we_o) begin
          s_dat_o <= m_dat_i;
        end
        if (resp_ok) begin
          s_ack_o <= dn_ack;
          s_err_o <= dn_err | tmo;
        end
      end
    end
  end

  // A timeout in the same cycle as a clear counts as the first event after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_flag_o <= 1'b0;
      timeout_cnt_o  <= '0;
    end else begin
      if (stat_clr_i) begin
        timeout_flag_o <= 1'b0;
        timeout_cnt_o  <= '0;
      end
      if (tmo) begin
        timeout_flag_o <= 1'b1;
        timeout_cnt_o  <= (&cnt_base) ? cnt_base : cnt_base + 1'b1;
      end
    end
  end

`ifdef EXT_BRIDGE_POSTED_WR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      posted_q     <= 1'b0;
      posted_err_o <= 1'b0;
    end else begin
      if (accept) begin
        posted_q <= s_we_i;
      end else if (done) begin
        posted_q <= 1'b0;
      end
      if (stat_clr_i) begin
        posted_err_o <= 1'b0;
      end
      if (done && posted_q && (dn_err || tmo)) begin
        posted_err_o <= 1'b1;
      end
    end
  end
`else
  assign posted_q     = 1'b0;
  assign posted_err_o = 1'b0;
`endif

endmodule
